// File: rtl/uart_xcvr.sv
// -----------------------------------------------------------------------------
// UartXcvr: buffered UART transmitter/receiver
//
// One TX FIFO feeds a frame serializer; a deserializer feeds one RX FIFO.
// Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stop
// bits(1). Each bit lasts P = CLOCKRATE/BAUDRATE clocks (P >= 4).
//
// Parameters:
//   BAUDRATE, CLOCKRATE  line bit rate and CLK frequency (Hz)
//   DATA_BITS            payload bits per frame, 5..8
//   PARITY               0 = none, 1 = even, 2 = odd
//   STOP_BITS            1 or 2
//   FIFO_DEPTH_LOG2      log2 of entries in each FIFO
//
// Ports:
//   CLK         clock, rising edge
//   RST         asynchronous active-high reset
//   send_flag   push send_data into the TX FIFO (ignored while full)
//   send_data   byte to transmit
//   recv_flag   pop the RX FIFO head (ignored while empty)
//   recv_data   RX FIFO head, first-word fall-through, zero while empty
//   recv_err    {parity_err, framing_err} of the RX FIFO head
//   sendable    TX FIFO not full
//   receivable  RX FIFO not empty
//   overrun     sticky: a frame was dropped on a full RX FIFO
//   Tx          registered serial output, idle high
//   Rx          serial input, asynchronous to CLK
//   loopback    (only with UART_LOOPBACK_EN) route TX stream into RX, hold Tx=1
//
// Build option: define UART_LOOPBACK_EN to add the loopback port.
// -----------------------------------------------------------------------------

// Small first-word fall-through FIFO shared by the TX and RX paths.
module uart_xcvr_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNTW  = DEPTH_LOG2 + 1;
  localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CNTW-1:0]       count;
  logic                  push_ok;
  logic                  pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Head is forced to zero while empty so the output is defined out of reset
  // without having to clear the storage array.
  assign dout = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves
  // the count unchanged.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

module uart_xcvr #(
  parameter int BAUDRATE        = 10000,
  parameter int CLOCKRATE       = 10000000,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 1,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
`ifdef UART_LOOPBACK_EN
  input  logic                 loopback,
`endif
  input  logic                 send_flag,
  input  logic [DATA_BITS-1:0] send_data,
  input  logic                 recv_flag,
  output logic [DATA_BITS-1:0] recv_data,
  output logic [1:0]           recv_err,
  output logic                 sendable,
  output logic                 receivable,
  output logic                 overrun,
  output logic                 Tx,
  input  logic                 Rx
);

  localparam int P  = CLOCKRATE / BAUDRATE;
  localparam int CW = $clog2(P);
  localparam int BW = $clog2(DATA_BITS);
  localparam int RW = DATA_BITS + 2;

  localparam logic [CW-1:0] CNT_LAST  = CW'(P - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(P / 2);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  // ---------------------------------------------------------------------------
  // Transmit path
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_empty;
  logic                 tx_full;
  logic                 tx_pop;
  logic                 tx_head_par;
  logic                 tx_last_tick;

  tx_state_t            tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_idx;
  logic                 tx_stop_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic                 tx_line;

  uart_xcvr_fifo #(
    .WIDTH      (DATA_BITS),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_tx_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (send_flag),
    .din   (send_data),
    .pop   (tx_pop),
    .dout  (tx_head),
    .empty (tx_empty),
    .full  (tx_full)
  );

  assign sendable     = !tx_full;
  assign tx_last_tick = (tx_cnt == CNT_LAST);
  assign tx_head_par  = (PARITY == 2) ? ~(^tx_head) : (^tx_head);

  // The serializer takes a byte either straight from idle or at the very end
  // of the last stop bit, so consecutive frames leave no idle gap.
  always_comb begin
    tx_pop = 1'b0;
    if (!tx_empty) begin
      if (tx_state == TX_IDLE)
        tx_pop = 1'b1;
      else if (tx_state == TX_STOP && tx_last_tick && tx_stop_idx == STOP_LAST)
        tx_pop = 1'b1;
    end
  end

  // Serializer FSM: tx_line is the registered line level; each state holds it
  // for exactly P clocks, counted by tx_cnt from 0 to P-1.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_state    <= TX_IDLE;
      tx_cnt      <= '0;
      tx_idx      <= '0;
      tx_stop_idx <= 1'b0;
      tx_shift    <= '0;
      tx_par      <= 1'b0;
      tx_line     <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_pop) begin
            tx_shift <= tx_head;
            tx_par   <= tx_head_par;
            tx_line  <= 1'b0;
            tx_cnt   <= '0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_last_tick) begin
            tx_line  <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_idx   <= '0;
            tx_cnt   <= '0;
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        TX_DATA: begin
          if (tx_last_tick) begin
            tx_cnt <= '0;
            if (tx_idx == BIT_LAST) begin
              if (PARITY != 0) begin
                tx_line  <= tx_par;
                tx_state <= TX_PARITY;
              end else begin
                tx_line     <= 1'b1;
                tx_stop_idx <= 1'b0;
                tx_state    <= TX_STOP;
              end
            end else begin
              tx_idx   <= tx_idx + BW'(1);
              tx_line  <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        TX_PARITY: begin
          if (tx_last_tick) begin
            tx_cnt      <= '0;
            tx_line     <= 1'b1;
            tx_stop_idx <= 1'b0;
            tx_state    <= TX_STOP;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        TX_STOP: begin
          if (tx_last_tick) begin
            tx_cnt <= '0;
            if (tx_stop_idx == STOP_LAST) begin
              if (tx_pop) begin
                tx_shift <= tx_head;
                tx_par   <= tx_head_par;
                tx_line  <= 1'b0;
                tx_state <= TX_START;
              end else begin
                tx_line  <= 1'b1;
                tx_state <= TX_IDLE;
              end
            end else begin
              tx_stop_idx <= 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        default: begin
          tx_line  <= 1'b1;
          tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Line selection (loopback option)
  // ---------------------------------------------------------------------------
  logic rx_src;

`ifdef UART_LOOPBACK_EN
  assign rx_src = loopback ? tx_line : Rx;
  assign Tx     = tx_line | loopback;
`else
  assign rx_src = Rx;
  assign Tx     = tx_line;
`endif

  // ---------------------------------------------------------------------------
  // Receive path
  // ---------------------------------------------------------------------------
  logic                 rx_meta;
  logic                 rx_sync;
  logic                 rx_prev;

  rx_state_t            rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_perr;
  logic                 rx_mid;
  logic                 rx_wr;
  logic                 rx_par_exp;
  logic [RW-1:0]        rx_din;
  logic [RW-1:0]        rx_dout;
  logic                 rx_empty;
  logic                 rx_full;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  // All three reset high so reset release does not look like a start edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_src;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_mid     = (rx_cnt == CNT_HALF);
  assign rx_wr      = (rx_state == RX_STOP) && rx_mid;
  assign rx_par_exp = (PARITY == 2) ? ~(^rx_shift) : (^rx_shift);
  assign rx_din     = {rx_perr, ~rx_sync, rx_shift};

  // Deserializer FSM: the edge cycle counts as 0 of the start bit, the counter
  // wraps every P clocks, and every bit is sampled when it reads P/2. The
  // state names the bit expected at the next mid-sample.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_perr  <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_cnt   <= CW'(1);
            rx_perr  <= 1'b0;
            rx_state <= RX_START;
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_sync) rx_state <= RX_IDLE;
        end
        default: begin
          rx_cnt <= (rx_cnt == CNT_LAST) ? '0 : rx_cnt + CW'(1);
          if (rx_mid) begin
            case (rx_state)
              RX_START: begin
                if (rx_sync) begin
                  rx_state <= RX_IDLE;
                end else begin
                  rx_idx   <= '0;
                  rx_state <= RX_DATA;
                end
              end
              RX_DATA: begin
                rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                if (rx_idx == BIT_LAST)
                  rx_state <= (PARITY != 0) ? RX_PARITY : RX_STOP;
                else
                  rx_idx <= rx_idx + BW'(1);
              end
              RX_PARITY: begin
                rx_perr  <= (rx_sync != rx_par_exp);
                rx_state <= RX_STOP;
              end
              RX_STOP: begin
                rx_state <= rx_sync ? RX_IDLE : RX_WAIT_HIGH;
              end
              default: rx_state <= RX_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  uart_xcvr_fifo #(
    .WIDTH      (RW),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_rx_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (rx_wr),
    .din   (rx_din),
    .pop   (recv_flag),
    .dout  (rx_dout),
    .empty (rx_empty),
    .full  (rx_full)
  );

  assign recv_data  = rx_dout[DATA_BITS-1:0];
  assign recv_err   = rx_dout[RW-1:DATA_BITS];
  assign receivable = !rx_empty;

  // Sticky overrun flag: a drop wins over a same-cycle pop so the loss is
  // never hidden; the next accepted pop afterwards clears it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      overrun <= 1'b0;
    else if (rx_wr && rx_full)
      overrun <= 1'b1;
    else if (recv_flag && !rx_empty)
      overrun <= 1'b0;
  end

endmodule

// File: tb/tb_uart_xcvr.sv
// -----------------------------------------------------------------------------
// tb_uart_xcvr: directed self-checking bench for uart_xcvr
//
// dut_a: P=16, even parity, 16-entry FIFOs; used for the transmit side and
//        for reset during a frame.
// dut_b: P=16, odd parity, 4-entry FIFOs; Rx driven directly by the bench
//        for receive, error flag, glitch and overrun cases.
// Inputs are driven and outputs sampled on the falling edge of CLK.
// -----------------------------------------------------------------------------
module tb_uart_xcvr;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;

  logic       a_send_flag;
  logic [7:0] a_send_data;
  logic       a_recv_flag;
  logic [7:0] a_recv_data;
  logic [1:0] a_recv_err;
  logic       a_sendable;
  logic       a_receivable;
  logic       a_overrun;
  logic       a_tx;
  logic       a_rx;

  logic       b_send_flag;
  logic [7:0] b_send_data;
  logic       b_recv_flag;
  logic [7:0] b_recv_data;
  logic [1:0] b_recv_err;
  logic       b_sendable;
  logic       b_receivable;
  logic       b_overrun;
  logic       b_tx;
  logic       b_rx;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  uart_xcvr #(
    .BAUDRATE        (10),
    .CLOCKRATE       (160),
    .DATA_BITS       (8),
    .PARITY          (1),
    .STOP_BITS       (1),
    .FIFO_DEPTH_LOG2 (4)
  ) dut_a (
    .CLK        (CLK),
    .RST        (RST),
    .send_flag  (a_send_flag),
    .send_data  (a_send_data),
    .recv_flag  (a_recv_flag),
    .recv_data  (a_recv_data),
    .recv_err   (a_recv_err),
    .sendable   (a_sendable),
    .receivable (a_receivable),
    .overrun    (a_overrun),
    .Tx         (a_tx),
    .Rx         (a_rx)
  );

  uart_xcvr #(
    .BAUDRATE        (10),
    .CLOCKRATE       (160),
    .DATA_BITS       (8),
    .PARITY          (2),
    .STOP_BITS       (1),
    .FIFO_DEPTH_LOG2 (2)
  ) dut_b (
    .CLK        (CLK),
    .RST        (RST),
    .send_flag  (b_send_flag),
    .send_data  (b_send_data),
    .recv_flag  (b_recv_flag),
    .recv_data  (b_recv_data),
    .recv_err   (b_recv_err),
    .sendable   (b_sendable),
    .receivable (b_receivable),
    .overrun    (b_overrun),
    .Tx         (b_tx),
    .Rx         (b_rx)
  );

  // One comparison: counts it, and on mismatch counts and reports the failure.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one frame onto dut_b's Rx, 16 clocks per bit; the line is left at
  // the stop level so the caller decides what follows.
  task automatic applyStimulus(input logic [7:0] data, input logic par,
                               input logic stop);
    b_rx = 1'b0;
    repeat (16) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      b_rx = data[i];
      repeat (16) @(negedge CLK);
    end
    b_rx = par;
    repeat (16) @(negedge CLK);
    b_rx = stop;
    repeat (16) @(negedge CLK);
  endtask

  // Check dut_a's Tx on every clock of one frame, starting at the current
  // falling edge (the first clock of the start bit).
  task automatic checkTxFrame(input logic [7:0] data, input logic par);
    logic [10:0] bits;
    bits = {1'b1, par, data, 1'b0};
    for (int k = 0; k < 11; k++) begin
      for (int c = 0; c < 16; c++) begin
        checkOutput($sformatf("tx_%02h_bit%0d_clk%0d", data, k, c),
                    16'(a_tx), 16'(bits[k]));
        @(negedge CLK);
      end
    end
  endtask

  task automatic popB();
    b_recv_flag = 1'b1;
    @(negedge CLK);
    b_recv_flag = 1'b0;
  endtask

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    a_send_flag = 1'b0; a_send_data = 8'h00; a_recv_flag = 1'b0; a_rx = 1'b1;
    b_send_flag = 1'b0; b_send_data = 8'h00; b_recv_flag = 1'b0; b_rx = 1'b1;
    RST = 1'b1;
    @(negedge CLK);

    // Reset state
    checkOutput("rst_a_tx",         16'(a_tx),         16'h1);
    checkOutput("rst_a_sendable",   16'(a_sendable),   16'h1);
    checkOutput("rst_a_receivable", 16'(a_receivable), 16'h0);
    checkOutput("rst_a_recv_data",  16'(a_recv_data),  16'h0);
    checkOutput("rst_a_recv_err",   16'(a_recv_err),   16'h0);
    checkOutput("rst_a_overrun",    16'(a_overrun),    16'h0);
    checkOutput("rst_b_tx",         16'(b_tx),         16'h1);
    checkOutput("rst_b_sendable",   16'(b_sendable),   16'h1);
    checkOutput("rst_b_receivable", 16'(b_receivable), 16'h0);
    checkOutput("rst_b_overrun",    16'(b_overrun),    16'h0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    $display("[TB] reset checks done");

    // Single frame 0xA5, even parity 0; Tx drops one clock after the push
    a_send_data = 8'hA5;
    a_send_flag = 1'b1;
    @(negedge CLK);
    a_send_flag = 1'b0;
    checkOutput("tx_idle_at_push", 16'(a_tx), 16'h1);
    @(negedge CLK);
    checkTxFrame(8'hA5, 1'b0);
    checkOutput("tx_idle_after_a5", 16'(a_tx), 16'h1);
    checkOutput("tx_sendable_idle", 16'(a_sendable), 16'h1);

    // Two frames back to back: 0x01 (parity 1) then 0x80 (parity 1); the
    // second push coincides with the first pop
    a_send_data = 8'h01;
    a_send_flag = 1'b1;
    @(negedge CLK);
    a_send_data = 8'h80;
    checkOutput("tx_idle_before_b2b", 16'(a_tx), 16'h1);
    @(negedge CLK);
    a_send_flag = 1'b0;
    checkTxFrame(8'h01, 1'b1);
    checkTxFrame(8'h80, 1'b1);
    checkOutput("tx_idle_after_b2b", 16'(a_tx), 16'h1);
    $display("[TB] transmit checks done");

    // Good frame 0x3C, odd parity bit 1
    applyStimulus(8'h3C, 1'b1, 1'b1);
    repeat (4) @(negedge CLK);
    checkOutput("rx_good_receivable", 16'(b_receivable), 16'h1);
    checkOutput("rx_good_data",       16'(b_recv_data),  16'h3C);
    checkOutput("rx_good_err",        16'(b_recv_err),   16'h0);
    popB();
    checkOutput("rx_good_popped", 16'(b_receivable), 16'h0);

    // Same frame, wrong parity bit
    applyStimulus(8'h3C, 1'b0, 1'b1);
    repeat (4) @(negedge CLK);
    checkOutput("rx_perr_receivable", 16'(b_receivable), 16'h1);
    checkOutput("rx_perr_data",       16'(b_recv_data),  16'h3C);
    checkOutput("rx_perr_err",        16'(b_recv_err),   16'h2);
    popB();

    // Same frame, stop bit low and line held low afterwards
    applyStimulus(8'h3C, 1'b1, 1'b0);
    repeat (40) @(negedge CLK);
    checkOutput("rx_ferr_receivable", 16'(b_receivable), 16'h1);
    checkOutput("rx_ferr_data",       16'(b_recv_data),  16'h3C);
    checkOutput("rx_ferr_err",        16'(b_recv_err),   16'h1);
    popB();
    repeat (40) @(negedge CLK);
    checkOutput("rx_ferr_no_new_frame", 16'(b_receivable), 16'h0);
    b_rx = 1'b1;
    repeat (20) @(negedge CLK);
    checkOutput("rx_ferr_line_high", 16'(b_receivable), 16'h0);

    // Recovery after the framing error: 0x81, odd parity bit 1
    applyStimulus(8'h81, 1'b1, 1'b1);
    repeat (4) @(negedge CLK);
    checkOutput("rx_recover_data", 16'(b_recv_data), 16'h81);
    checkOutput("rx_recover_err",  16'(b_recv_err),  16'h0);
    popB();

    // Start glitch: 4 clocks low
    b_rx = 1'b0;
    repeat (4) @(negedge CLK);
    b_rx = 1'b1;
    repeat (40) @(negedge CLK);
    checkOutput("rx_glitch_receivable", 16'(b_receivable), 16'h0);

    // Overrun: five frames into a four-entry FIFO
    applyStimulus(8'h11, 1'b1, 1'b1);
    applyStimulus(8'h22, 1'b1, 1'b1);
    applyStimulus(8'h07, 1'b0, 1'b1);
    applyStimulus(8'h44, 1'b1, 1'b1);
    checkOutput("ovr_after_four", 16'(b_overrun), 16'h0);
    applyStimulus(8'h55, 1'b1, 1'b1);
    repeat (4) @(negedge CLK);
    checkOutput("ovr_set",        16'(b_overrun),    16'h1);
    checkOutput("ovr_receivable", 16'(b_receivable), 16'h1);
    checkOutput("ovr_head0",      16'(b_recv_data),  16'h11);
    popB();
    checkOutput("ovr_cleared", 16'(b_overrun),   16'h0);
    checkOutput("ovr_head1",   16'(b_recv_data), 16'h22);
    popB();
    checkOutput("ovr_head2",     16'(b_recv_data), 16'h07);
    checkOutput("ovr_head2_err", 16'(b_recv_err),  16'h0);
    popB();
    checkOutput("ovr_head3", 16'(b_recv_data), 16'h44);
    popB();
    checkOutput("ovr_empty", 16'(b_receivable), 16'h0);
    $display("[TB] receive checks done");

    // Fill the TX FIFO (17 pushes: one goes straight out), then reset in DATA
    a_send_flag = 1'b1;
    for (int i = 0; i < 17; i++) begin
      a_send_data = 8'hF0 ^ 8'(i);
      @(negedge CLK);
    end
    a_send_flag = 1'b0;
    repeat (20) @(negedge CLK);
    checkOutput("tx_full_sendable", 16'(a_sendable), 16'h0);
    RST = 1'b1;
    #1;
    checkOutput("rst_mid_tx",       16'(a_tx),       16'h1);
    checkOutput("rst_mid_sendable", 16'(a_sendable), 16'h1);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      checkOutput($sformatf("rst_quiet_%0d", i), 16'(a_tx), 16'h1);
    end
    checkOutput("rst_quiet_sendable", 16'(a_sendable), 16'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
